// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and periodic modes.
// A LOAD with a non-zero value starts the count. TC pulses for one cycle on
// each terminal event: the step from Q==1, or a LOAD of zero. In periodic
// mode the count restarts from the reload register and keeps running.
// ABORT returns the block to IDLE with Q cleared.
// Every output comes from a flop or is decoded from the state register.
module countdown_timer #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic             EN,
   input  logic             AUTO_RELOAD,
   input  logic             ABORT,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             TC
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_next;
   logic             tc_reg;
   logic             tc_next;

   // State, count, reload value and TC are all registered; reset clears them without waiting for a clock
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= ST_IDLE;
         count  <= '0;
         reload <= '0;
         tc_reg <= 1'b0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         reload <= reload_next;
         tc_reg <= tc_next;
      end
   end

   // Next-state logic: ABORT beats LOAD, LOAD beats counting, otherwise hold; TC defaults low
   always_comb begin
      state_next  = state;
      count_next  = count;
      reload_next = reload;
      tc_next     = 1'b0;

      if (ABORT) begin
         state_next = ST_IDLE;
         count_next = '0;
      end else if (LOAD) begin
         reload_next = LOAD_VAL;
         if (LOAD_VAL != '0) begin
            state_next = ST_RUN;
            count_next = LOAD_VAL;
         end else begin
            state_next = ST_DONE;
            count_next = '0;
            tc_next    = 1'b1;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (count == '0) begin
                  state_next = ST_DONE;
               end else if (EN) begin
                  if (count == WIDTH'(1)) begin
                     tc_next = 1'b1;
                     if (AUTO_RELOAD) begin
                        count_next = reload;
                     end else begin
                        state_next = ST_DONE;
                        count_next = '0;
                     end
                  end else begin
                     count_next = count - WIDTH'(1);
                  end
               end
            end
            ST_DONE: begin
               state_next = ST_DONE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from the registers, with no path from the inputs
   always_comb begin
      Q    = count;
      TC   = tc_reg;
      BUSY = (state == ST_RUN);
      DONE = (state == ST_DONE);
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven bench for countdown_timer (WIDTH=4).
// The expected values for each driven vector go into a scoreboard queue.
// They are taken off the queue and compared after the next clock edge.
module tb_countdown_timer;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic         LOAD = 1'b0;
   logic [W-1:0] LOAD_VAL = '0;
   logic         EN = 1'b0;
   logic         AUTO_RELOAD = 1'b0;
   logic         ABORT = 1'b0;
   logic [W-1:0] Q;
   logic         BUSY;
   logic         DONE;
   logic         TC;

   typedef struct {
      logic         ld;
      logic [W-1:0] lv;
      logic         en;
      logic         ar;
      logic         ab;
      logic [W-1:0] q;
      logic         busy;
      logic         done;
      logic         tc;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
      logic         tc;
      string        tag;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   countdown_timer #(.WIDTH(W)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .LOAD(LOAD),
      .LOAD_VAL(LOAD_VAL),
      .EN(EN),
      .AUTO_RELOAD(AUTO_RELOAD),
      .ABORT(ABORT),
      .Q(Q),
      .BUSY(BUSY),
      .DONE(DONE),
      .TC(TC)
   );

   // 10 time-unit free-running clock
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic en,
                               input logic ar, input logic ab, input logic [W-1:0] q,
                               input logic busy, input logic done, input logic tc);
      vec_t v;
      v.ld = ld; v.lv = lv; v.en = en; v.ar = ar; v.ab = ab;
      v.q = q; v.busy = busy; v.done = done; v.tc = tc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".Q"}, 8'(Q), 8'(e.q));
         chk({e.tag, ".BUSY"}, 8'(BUSY), 8'(e.busy));
         chk({e.tag, ".DONE"}, 8'(DONE), 8'(e.done));
         chk({e.tag, ".TC"}, 8'(TC), 8'(e.tc));
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      exp_t e;
      @(negedge CLK);
      LOAD = v.ld; LOAD_VAL = v.lv; EN = v.en; AUTO_RELOAD = v.ar; ABORT = v.ab;
      e.q = v.q; e.busy = v.busy; e.done = v.done; e.tc = v.tc; e.tag = tag;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      checkOutput();
   endtask

   initial begin
      // The table columns are: ld lv en ar ab | q busy done tc
      // One-shot count from 3
      vecs.push_back(mk(1, 3, 1, 0, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 0));
      // Periodic count from 4
      vecs.push_back(mk(1, 4, 1, 1, 0,  4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  4, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  4, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  2, 1, 0, 0));
      // ABORT beats LOAD, then LOAD on its own
      vecs.push_back(mk(1, 7, 1, 1, 1,  0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 1, 0, 0,  7, 1, 0, 0));
      // Pause with EN low
      vecs.push_back(mk(1, 5, 1, 0, 0,  5, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 1));
      // LOAD of zero, from DONE and then from RUN in periodic mode
      vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 1, 0));
      vecs.push_back(mk(1, 2, 1, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 0,  0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0, 0, 1, 0));
      // Periodic with N=1 holds TC high while EN stays high
      vecs.push_back(mk(1, 1, 1, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0,  1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  1, 1, 0, 1));
      // A LOAD during RUN restarts the count without a TC, then ABORT and idle hold
      vecs.push_back(mk(1, 3, 1, 0, 0,  3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0));
      vecs.push_back(mk(1, 6, 1, 0, 0,  6, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0));

      // Outputs must clear as soon as reset is asserted
      #1;
      chk("rst.Q", 8'(Q), 8'd0);
      chk("rst.BUSY", 8'(BUSY), 8'd0);
      chk("rst.DONE", 8'(DONE), 8'd0);
      chk("rst.TC", 8'(TC), 8'd0);

      // Inputs are ignored while reset is held, even across a clock edge
      LOAD = 1'b1; LOAD_VAL = 4'd9; EN = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst_ignore.Q", 8'(Q), 8'd0);
      chk("rst_ignore.BUSY", 8'(BUSY), 8'd0);
      @(negedge CLK);
      LOAD = 1'b0; LOAD_VAL = '0;
      RESET = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Full-range one-shot count from 15 with no wrap
      applyStimulus(mk(1, 15, 1, 0, 0, 15, 1, 0, 0), "max_load");
      for (int i = 14; i >= 0; i--) begin
         applyStimulus(mk(0, 0, 1, 0, 0, W'(i), i != 0, i == 0, i == 0),
                       $sformatf("max_q%0d", i));
      end
      applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 1, 0), "max_hold");

      // Reset asserted between clock edges while counting at Q=6
      applyStimulus(mk(1, 8, 1, 0, 0, 8, 1, 0, 0), "mid_load");
      applyStimulus(mk(0, 0, 1, 0, 0, 7, 1, 0, 0), "mid_q7");
      applyStimulus(mk(0, 0, 1, 0, 0, 6, 1, 0, 0), "mid_q6");
      #2;
      RESET = 1'b0;
      #1;
      chk("mid_rst.Q", 8'(Q), 8'd0);
      chk("mid_rst.BUSY", 8'(BUSY), 8'd0);
      chk("mid_rst.TC", 8'(TC), 8'd0);
      chk("mid_rst.DONE", 8'(DONE), 8'd0);
      @(negedge CLK);
      RESET = 1'b1;
      applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), "post_rst_idle0");
      applyStimulus(mk(0, 0, 1, 1, 0, 0, 0, 0, 0), "post_rst_idle1");
      applyStimulus(mk(1, 2, 1, 0, 0, 2, 1, 0, 0), "post_rst_load");
      applyStimulus(mk(0, 0, 1, 0, 0, 1, 1, 0, 0), "post_rst_q1");
      applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 1, 1), "post_rst_q0");

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
